// File: rtl/stack_ctrl.sv
// -----------------------------------------------------------------------------
// stack_ctrl
//   LIFO stack with a four-state request/acknowledge handshake towards a
//   control unit. Each request (cs_stack == 1 seen in IDLE) performs exactly
//   one push or pop. ready_stack then stays high until the request is
//   released.
//
// Parameters
//   DATA_W  stack word width in bits
//   DEPTH   number of entries (power of two, >= 2)
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset of all state (not the memory)
//   cs_stack     request strobe; only a solid 1 counts as a request
//   push         1 = push, 0 = pop; latched with the request
//   sdata        push data; latched with the request
//   clr_err      synchronous clear of ovf/unf (a same-cycle set wins)
//   ready_stack  completion, held until cs_stack is released
//   pop_data     last popped word (0 after a pop on empty)
//   full/empty   occupancy decoded from the stack pointer
//   ovf/unf      sticky overflow / underflow flags
//
// Configuration
//   STACK_ERR_FLAGS_EN  when defined, ovf/unf are live sticky flags; when not
//                       defined, ovf/unf read 0 and clr_err has no effect.
// -----------------------------------------------------------------------------
module stack_ctrl #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs_stack,
  input  logic              push,
  input  logic [DATA_W-1:0] sdata,
  input  logic              clr_err,
  output logic              ready_stack,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty,
  output logic              ovf,
  output logic              unf
);

  localparam int              AW      = $clog2(DEPTH);
  localparam int              SP_W    = AW + 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(DEPTH);
  localparam logic [SP_W-1:0] SP_ZERO = {SP_W{1'b0}};
  localparam logic [SP_W-1:0] SP_ONE  = {{(SP_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXEC    = 2'd1,
    DONE    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [SP_W-1:0]     sp_q, sp_d;
  logic                push_q, push_d;
  logic [DATA_W-1:0]   sdata_q, sdata_d;
  logic [DATA_W-1:0]   pop_data_q, pop_data_d;
  logic                ready_q, ready_d;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                req_s;
  logic                is_full_s;
  logic                is_empty_s;
  logic                wr_en_s;
  logic                ovf_set_s;
  logic                unf_set_s;
  logic [SP_W-1:0]     sp_dec_s;
  logic [AW-1:0]       wr_idx_s;
  logic [AW-1:0]       rd_idx_s;

  // Equality rather than a truth test so that X/Z on the strobe never opens a request.
  assign req_s      = (cs_stack == 1'b1);
  assign is_full_s  = (sp_q == SP_FULL);
  assign is_empty_s = (sp_q == SP_ZERO);
  assign sp_dec_s   = sp_q - SP_ONE;
  // Indices drop the pointer MSB; only used when the pointer is in range.
  assign wr_idx_s   = sp_q[AW-1:0];
  assign rd_idx_s   = sp_dec_s[AW-1:0];

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: one operation per request, RELEASE waits for the strobe to drop.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_s) state_d = EXEC;
        else       state_d = IDLE;
      end
      EXEC:    state_d = DONE;
      DONE:    state_d = RELEASE;
      RELEASE: begin
        if (req_s) state_d = RELEASE;
        else       state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath logic: latch the request, execute it in EXEC, drive ready.
  always_comb begin
    push_d     = push_q;
    sdata_d    = sdata_q;
    sp_d       = sp_q;
    pop_data_d = pop_data_q;
    wr_en_s    = 1'b0;
    ovf_set_s  = 1'b0;
    unf_set_s  = 1'b0;
    // ready is registered, so it follows the state being entered.
    ready_d    = (state_d == DONE) || (state_d == RELEASE);
    case (state_q)
      IDLE: begin
        if (req_s) begin
          push_d  = push;
          sdata_d = sdata;
        end else begin
          push_d  = push_q;
          sdata_d = sdata_q;
        end
      end
      EXEC: begin
        if (push_q) begin
          if (!is_full_s) begin
            wr_en_s = 1'b1;
            sp_d    = sp_q + SP_ONE;
          end else begin
            ovf_set_s = 1'b1;
          end
        end else begin
          if (!is_empty_s) begin
            sp_d       = sp_dec_s;
            pop_data_d = mem[rd_idx_s];
          end else begin
            pop_data_d = {DATA_W{1'b0}};
            unf_set_s  = 1'b1;
          end
        end
      end
      default: begin
        wr_en_s = 1'b0;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp_q       <= SP_ZERO;
      push_q     <= 1'b0;
      sdata_q    <= {DATA_W{1'b0}};
      pop_data_q <= {DATA_W{1'b0}};
      ready_q    <= 1'b0;
    end else begin
      sp_q       <= sp_d;
      push_q     <= push_d;
      sdata_q    <= sdata_d;
      pop_data_q <= pop_data_d;
      ready_q    <= ready_d;
    end
  end

  // Stack storage; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem[wr_idx_s] <= sdata_q;
    end
  end

`ifdef STACK_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  // Sticky error flags; an error in the same cycle as clr_err leaves the flag set.
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (clr_err) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
      unf_d = unf_q;
    end
    if (ovf_set_s) ovf_d = 1'b1;
    else           ovf_d = ovf_d;
    if (unf_set_s) unf_d = 1'b1;
    else           unf_d = unf_d;
  end

  // Error flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign ovf = ovf_q;
  assign unf = unf_q;
`else
  // Flags disabled: inputs and error strobes are intentionally left without a load.
  logic unused_err_s;
  assign unused_err_s = clr_err ^ ovf_set_s ^ unf_set_s;
  assign ovf = 1'b0;
  assign unf = 1'b0;
`endif

  assign ready_stack = ready_q;
  assign pop_data    = pop_data_q;
  assign full        = is_full_s;
  assign empty       = is_empty_s;

endmodule

// File: tb/tb_stack_ctrl.sv
`timescale 1ns/1ps
module tb_stack_ctrl;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 16;

`ifdef STACK_ERR_FLAGS_EN
  localparam logic FLAGS_EN = 1'b1;
`else
  localparam logic FLAGS_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              cs_stack;
  logic              push;
  logic [DATA_W-1:0] sdata;
  logic              clr_err;
  logic              ready_stack;
  logic [DATA_W-1:0] pop_data;
  logic              full;
  logic              empty;
  logic              ovf;
  logic              unf;

  always #5 clk = ~clk;

  stack_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .cs_stack(cs_stack), .push(push),
    .sdata(sdata), .clr_err(clr_err), .ready_stack(ready_stack),
    .pop_data(pop_data), .full(full), .empty(empty), .ovf(ovf), .unf(unf)
  );

  // Behavioural model: a queue as the stack plus the observable handshake/flag state.
  logic [DATA_W-1:0] m_stack[$];
  logic [DATA_W-1:0] m_pop;
  logic              m_ready;
  logic              m_ovf;
  logic              m_unf;
  logic              chk_en;
  int                n_vec = 0;
  int                n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("ready_stack", {31'd0, ready_stack}, {31'd0, m_ready});
      check("pop_data",    {16'd0, pop_data},    {16'd0, m_pop});
      check("full",        {31'd0, full},        {31'd0, (m_stack.size() == DEPTH)});
      check("empty",       {31'd0, empty},       {31'd0, (m_stack.size() == 0)});
      check("ovf",         {31'd0, ovf},         {31'd0, m_ovf & FLAGS_EN});
      check("unf",         {31'd0, unf},         {31'd0, m_unf & FLAGS_EN});
    end
  end

  task automatic model_reset();
    m_stack.delete();
    m_pop   = 16'h0000;
    m_ready = 1'b0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
  endtask

  // Effect of one completed operation (clr applied first so an error set wins).
  task automatic model_exec(input logic op_push, input logic [DATA_W-1:0] d, input logic clr);
    if (clr) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (op_push) begin
      if (m_stack.size() < DEPTH) m_stack.push_back(d);
      else                        m_ovf = 1'b1;
    end else begin
      if (m_stack.size() > 0) m_pop = m_stack.pop_back();
      else begin
        m_pop = 16'h0000;
        m_unf = 1'b1;
      end
    end
    m_ready = 1'b1;
  endtask

  // One full handshake: request, scramble push/sdata after latch, hold, release.
  task automatic do_op(input logic op_push, input logic [DATA_W-1:0] d, input int hold, input logic clr_at_exec);
    int h;
    h = (hold < 1) ? 1 : hold;
    @(negedge clk);
    cs_stack = 1'b1; push = op_push; sdata = d;
    @(posedge clk);                       // request edge
    @(negedge clk);
    push = ~op_push; sdata = 16'hDEAD; clr_err = clr_at_exec;
    @(posedge clk);                       // operation edge
    model_exec(op_push, d, clr_at_exec);
    @(negedge clk);
    clr_err = 1'b0;
    repeat (h) @(negedge clk);
    cs_stack = 1'b0;
    @(posedge clk);
    m_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_err = 1'b1;
    @(posedge clk);
    m_ovf = 1'b0;
    m_unf = 1'b0;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; cs_stack = 1'b0; push = 1'b0; sdata = 16'h0000; clr_err = 1'b0;
    chk_en = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_ready", {31'd0, ready_stack}, 32'd0);
    check("rst_empty", {31'd0, empty},       32'd1);
    check("rst_full",  {31'd0, full},        32'd0);
    check("rst_pop",   {16'd0, pop_data},    32'd0);
    check("rst_ovf",   {31'd0, ovf},         32'd0);
    check("rst_unf",   {31'd0, unf},         32'd0);
    reset = 1'b1;

    // Push 0x1234 with explicit latency checks.
    @(negedge clk);
    cs_stack = 1'b1; push = 1'b1; sdata = 16'h1234;
    @(posedge clk);
    @(negedge clk);
    check("lat_ready_early", {31'd0, ready_stack}, 32'd0);
    @(posedge clk);
    model_exec(1'b1, 16'h1234, 1'b0);
    @(negedge clk);
    check("lat_ready", {31'd0, ready_stack}, 32'd1);
    check("lat_empty", {31'd0, empty},       32'd0);
    @(negedge clk);
    cs_stack = 1'b0;
    @(posedge clk);
    m_ready = 1'b0;
    @(negedge clk);
    check("release_ready", {31'd0, ready_stack}, 32'd0);

    // LIFO order; held request serviced only once.
    do_op(1'b1, 16'hAAAA, 3, 1'b0);
    do_op(1'b1, 16'h5555, 1, 1'b0);
    do_op(1'b0, 16'h0000, 2, 1'b0);
    @(negedge clk);
    check("pop_5555", {16'd0, pop_data}, 32'h5555);
    do_op(1'b0, 16'h0000, 4, 1'b0);
    @(negedge clk);
    check("pop_aaaa", {16'd0, pop_data}, 32'hAAAA);
    do_op(1'b0, 16'h0000, 1, 1'b0);
    @(negedge clk);
    check("drain_empty", {31'd0, empty}, 32'd1);
    do_op(1'b1, 16'h0F0F, 1, 1'b0);
    @(negedge clk);
    check("push_keeps_pop", {16'd0, pop_data}, 32'h1234);
    do_op(1'b0, 16'h0000, 1, 1'b0);

    // Pop on empty, then clear.
    do_op(1'b0, 16'h0000, 2, 1'b0);
    @(negedge clk);
    check("unf_pop0", {16'd0, pop_data}, 32'd0);
    check("unf_set",  {31'd0, unf},      {31'd0, FLAGS_EN});
    pulse_clr();
    @(negedge clk);
    check("unf_clr", {31'd0, unf}, 32'd0);

    // Fill, overflow, set-wins-over-clear, pop the last real word.
    for (int i = 0; i < DEPTH; i++) do_op(1'b1, 16'h1000 + 16'(i), 1 + (i % 3), 1'b0);
    @(negedge clk);
    check("fill_full", {31'd0, full}, 32'd1);
    do_op(1'b1, 16'hBEEF, 1, 1'b0);
    @(negedge clk);
    check("ovf_set",  {31'd0, ovf},  {31'd0, FLAGS_EN});
    check("ovf_full", {31'd0, full}, 32'd1);
    do_op(1'b1, 16'hBEEF, 1, 1'b1);
    @(negedge clk);
    check("ovf_set_wins", {31'd0, ovf}, {31'd0, FLAGS_EN});
    pulse_clr();
    @(negedge clk);
    check("ovf_clr", {31'd0, ovf}, 32'd0);
    do_op(1'b0, 16'h0000, 1, 1'b0);
    @(negedge clk);
    check("pop_after_ovf", {16'd0, pop_data}, 32'h100F);
    for (int i = 0; i < DEPTH - 1; i++) do_op(1'b0, 16'h0000, 1 + (i % 2), 1'b0);
    do_op(1'b0, 16'h0000, 1, 1'b1);
    @(negedge clk);
    check("unf_set_wins", {31'd0, unf}, {31'd0, FLAGS_EN});
    pulse_clr();

    // Reset during EXEC of a push, strobe held through reset.
    do_op(1'b1, 16'h2222, 1, 1'b0);
    do_op(1'b1, 16'h3333, 1, 1'b0);
    @(negedge clk);
    cs_stack = 1'b1; push = 1'b1; sdata = 16'h7777;
    @(posedge clk);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("abort_empty", {31'd0, empty},       32'd1);
    check("abort_ready", {31'd0, ready_stack}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    model_exec(1'b1, 16'h7777, 1'b0);
    @(negedge clk);
    check("rerun_ready", {31'd0, ready_stack}, 32'd1);
    check("rerun_empty", {31'd0, empty},       32'd0);
    @(negedge clk);
    cs_stack = 1'b0;
    @(posedge clk);
    m_ready = 1'b0;
    do_op(1'b0, 16'h0000, 1, 1'b0);
    @(negedge clk);
    check("rerun_pop", {16'd0, pop_data}, 32'h7777);
    check("rerun_drained", {31'd0, empty}, 32'd1);

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/stack_ctrl.md
STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 Parameter DATA_W, default 16, stack word width in bits.
REQ-002 Parameter DEPTH, default 16, number of stack entries, power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
REQ-005 cs_stack  input  1  request strobe from control unit; only logic 1 is a request, 0/Z/X are idle.
REQ-006 push  input  1  operation select, sampled with the request: 1 = push, 0 = pop.
REQ-007 sdata  input  DATA_W  push data, sampled with the request.
REQ-008 ready_stack  output  1  completion; high from the completion cycle until the request is released.
REQ-009 pop_data  output  DATA_W  popped word, valid while ready_stack is high after a pop.
REQ-010 full  output  1  high when the stack holds DEPTH entries.
REQ-011 empty  output  1  high when the stack holds 0 entries.
REQ-012 ovf  output  1  sticky overflow flag.
REQ-013 unf  output  1  sticky underflow flag.
REQ-014 clr_err  input  1  synchronous clear of ovf and unf.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, EXEC, DONE and RELEASE.
REQ-016 IDLE->EXEC when cs_stack==1 at a clock edge; push and sdata are latched on that edge.
REQ-017 EXEC SHALL perform the operation in one cycle, then go to DONE.
- Push, not full: write mem[sp], sp+1.
- Pop, not empty: sp-1, pop_data = mem[sp-1].
REQ-018 In DONE, ready_stack SHALL be 1, and the FSM SHALL go to RELEASE.
REQ-019 In RELEASE, ready_stack SHALL stay 1 while cs_stack==1; when cs_stack!=1, ready_stack SHALL drop to 0 and the FSM SHALL go to IDLE in the same cycle.
REQ-020 Latency SHALL be 2 cycles: request edge to ready_stack high.
REQ-021 A request that is held high SHALL never be serviced twice; a new request requires a return to IDLE.
REQ-022 Stack pointer sp SHALL be clog2(DEPTH)+1 bits, range 0..DEPTH, and SHALL never wrap.
REQ-023 full = (sp==DEPTH) and empty = (sp==0), decoded combinationally from sp.
REQ-024 Push while full: no write, sp unchanged, ovf set, handshake still completes.
REQ-025 Pop while empty: sp unchanged, pop_data = 0, unf set, handshake still completes.
REQ-026 pop_data SHALL hold its last value until the next pop completes; a push SHALL NOT change it.
REQ-027 If clr_err and a flag-setting error occur in the same cycle, the set SHALL win.
REQ-028 push and sdata changes after the request is latched SHALL be ignored.

Reset
REQ-029 Asserting reset (0) SHALL clear all state asynchronously: FSM=IDLE, sp=0, ready_stack=0, pop_data=0, ovf=0, unf=0; memory contents are not cleared.
REQ-030 Reset asserted mid-operation SHALL abort the operation, with no partial sp update.
REQ-031 After reset release, cs_stack held at 1 SHALL be treated as a new request on the next edge.

Configuration
REQ-032 Macro STACK_ERR_FLAGS_EN SHALL control the error flags.
- Defined: ovf and unf behave per REQ-024, REQ-025 and REQ-027.
- Undefined: ovf and unf are tied to 0, clr_err is ignored, ports are retained, and all other behaviour is unchanged.

Verification
REQ-033 Reset, then push 0x1234 (cs_stack=1, push=1, held) -> ready_stack=1 two cycles later; empty=0; ready_stack=0 in the cycle after cs_stack goes Z.
REQ-034 Push 0xAAAA then 0x5555, pop, pop -> pop_data 0x5555 then 0xAAAA; empty=1 at the end.
REQ-035 Push DEPTH words, then push 0xBEEF -> full=1, ovf=1, sp unchanged; next pop returns the DEPTH-th word, not 0xBEEF.
REQ-036 Pop on empty -> ready_stack still asserted, pop_data=0, unf=1; clr_err=1 for one cycle -> ovf=unf=0.
REQ-037 Reset pulled low during EXEC of a push -> empty=1 and ready_stack=0 immediately; cs_stack held high -> fresh request serviced after reset release.
REQ-038 Build without STACK_ERR_FLAGS_EN, repeat REQ-035 -> ovf stays 0, and the data and pointer results are identical.
